imem_loader: RTL and testbench

Sequencer that fills the 128-word instruction memory of the single-cycle/pipelined ARM (LEGv8) processor from an 8-bit byte stream, so programs are loaded at run time instead of from a fixed initial image. It accepts a load command with a word count, assembles incoming bytes little-endian into 32-bit instructions, and writes them to consecutive addresses from 0 through a write port on the instruction RAM. While a load is in progress it holds the core stalled.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/word_assembler.sv | 38 +++
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_pkg                                                             |
// | Shared definitions for the LEGv8 instruction RAM and its loader.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package imem_pkg;

  localparam int IMEM_ADDR_W = 7;
  localparam int IMEM_DEPTH  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_assembler                                                       |
// | Packs four bytes little-endian into a 32-bit instruction word.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;

  // Bytes are inserted in place rather than shifted, so byte k always lands at [8k+7:8k].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (clear) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (load_en) begin
      r_word[{r_idx, 3'b000} +: 8] <= byte_in;
      r_idx                        <= r_idx + 2'd1;
    end
  end

  assign word = r_word;
  assign last = (r_idx == 2'd3);

endmodule : word_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_loader                                                          |
// | Fills the instruction RAM from a byte stream while stalling the core.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imem_loader
  import imem_pkg::*;
#(
  parameter int N      = 32,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [N-1:0]      wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] c_max_len = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t   r_state;
  loader_state_t   w_state_next;
  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] r_count;
  logic            r_err;

  logic            w_len_ok;
  logic            w_start_ok;
  logic            w_accept;
  logic            w_last;
  logic [31:0]     w_word;
  logic [ADDR_W:0] w_count_inc;

  assign w_len_ok    = (len != '0) && (len <= c_max_len);
  assign w_start_ok  = (r_state == IDLE) && start && w_len_ok;
  // Abort takes priority: a byte presented alongside it is dropped.
  assign w_accept    = (r_state == LOAD) && s_valid && !abort;
  assign w_count_inc = r_count + 1'b1;

  word_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .load_en (w_accept),
    .clear   (w_start_ok),
    .byte_in (s_data),
    .word    (w_word),
    .last    (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = w_len_ok ? LOAD : DONE;
        end
      end
      LOAD: begin
        if (abort) begin
          w_state_next = DONE;
        end else if (w_accept && w_last) begin
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        if ((w_count_inc == r_len) || abort) begin
          w_state_next = DONE;
        end else begin
          w_state_next = LOAD;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // A legal start clears the sticky error; an illegal one raises it.
            r_err <= !w_len_ok;
          end
          if (w_start_ok) begin
            r_len   <= len;
            r_count <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            r_err <= 1'b1;
          end
        end
        WRITE: begin
          r_count <= w_count_inc;
          if (abort) begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Write port is decoded from registered state, so the RAM sees no input-to-output path.
  assign s_ready   = (r_state == LOAD);
  assign we        = (r_state == WRITE);
  assign waddr     = r_count[ADDR_W-1:0];
  assign wdata     = w_word;
  assign core_hold = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign err       = r_err;
  assign count     = r_count;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_loader                                                       |
// | Directed self-checking bench for imem_loader.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        abort;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        we;
  logic [6:0]  waddr;
  logic [31:0] wdata;
  logic        core_hold;
  logic        done;
  logic        err;
  logic [7:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0]  log_addr[$];
  logic [31:0] log_data[$];

  imem_loader #(.N(32), .ADDR_W(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .core_hold (core_hold),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write strobe seen by the RAM is recorded mid-cycle.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      log_addr.push_back(waddr);
      log_data.push_back(wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    if (waited >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte_timeout s_ready=%b required=1", s_ready);
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_tests++; if (s_ready !== 1'b0)     begin n_fail++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    n_tests++; if (we !== 1'b0)          begin n_fail++; $display("FAIL reset_we got=%b exp=0", we); end
    n_tests++; if (waddr !== 7'd0)       begin n_fail++; $display("FAIL reset_waddr got=%h exp=0", waddr); end
    n_tests++; if (wdata !== 32'd0)      begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    n_tests++; if (core_hold !== 1'b0)   begin n_fail++; $display("FAIL reset_core_hold got=%b exp=0", core_hold); end
    n_tests++; if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_tests++; if (err !== 1'b0)         begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    n_tests++; if (count !== 8'd0)       begin n_fail++; $display("FAIL reset_count got=%h exp=0", count); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    int base;
    base = log_addr.size();
    do_start(8'd1);
    n_tests++; if (core_hold !== 1'b1 || s_ready !== 1'b1) begin n_fail++; $display("FAIL single_hold_ready got=%b%b exp=11", core_hold, s_ready); end
    send_byte(8'h1f); send_byte(8'h00); send_byte(8'h00); send_byte(8'hb4);
    n_tests++; if (we !== 1'b1)          begin n_fail++; $display("FAIL single_we got=%b exp=1", we); end
    n_tests++; if (waddr !== 7'd0)       begin n_fail++; $display("FAIL single_waddr got=%h exp=0", waddr); end
    n_tests++; if (wdata !== 32'hb400001f) begin n_fail++; $display("FAIL single_wdata got=%h exp=b400001f", wdata); end
    n_tests++; if (s_ready !== 1'b0)     begin n_fail++; $display("FAIL single_ready_in_write got=%b exp=0", s_ready); end
    step();
    n_tests++; if (done !== 1'b1)        begin n_fail++; $display("FAIL single_done got=%b exp=1", done); end
    n_tests++; if (count !== 8'd1)       begin n_fail++; $display("FAIL single_count got=%h exp=1", count); end
    n_tests++; if (err !== 1'b0)         begin n_fail++; $display("FAIL single_err got=%b exp=0", err); end
    step();
    n_tests++; if (core_hold !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL single_idle hold_done=%b%b exp=00", core_hold, done); end
    n_tests++; if (log_addr.size() - base !== 1) begin n_fail++; $display("FAIL single_we_pulses got=%0d exp=1", log_addr.size() - base); end
  endtask

  task automatic test_full_backpressure();
    int base;
    int bad_data;
    int hold_bad;
    logic [7:0]  b;
    logic [31:0] exp_w;
    base     = log_addr.size();
    hold_bad = 0;
    bad_data = 0;
    do_start(8'd128);
    for (int i = 0; i < 512; i++) begin
      b = 8'((i * 37 + 5) & 255);
      repeat ($urandom_range(0, 2)) begin
        step();
        if (core_hold !== 1'b1) hold_bad++;
      end
      send_byte(b);
      if (core_hold !== 1'b1) hold_bad++;
    end
    n_tests++; if (we !== 1'b1 || waddr !== 7'd127) begin n_fail++; $display("FAIL full_last_write we=%b waddr=%h exp we=1 waddr=7f", we, waddr); end
    step();
    n_tests++; if (done !== 1'b1)        begin n_fail++; $display("FAIL full_done got=%b exp=1", done); end
    n_tests++; if (count !== 8'h80)      begin n_fail++; $display("FAIL full_count got=%h exp=80", count); end
    n_tests++; if (err !== 1'b0)         begin n_fail++; $display("FAIL full_err got=%b exp=0", err); end
    n_tests++; if (hold_bad !== 0)       begin n_fail++; $display("FAIL full_core_hold drops=%0d exp=0", hold_bad); end
    n_tests++; if (log_addr.size() - base !== 128) begin n_fail++; $display("FAIL full_we_pulses got=%0d exp=128", log_addr.size() - base); end
    if (log_addr.size() - base == 128) begin
      for (int w = 0; w < 128; w++) begin
        for (int k = 0; k < 4; k++) exp_w[8*k +: 8] = 8'(((4*w + k) * 37 + 5) & 255);
        if (log_addr[base + w] !== 7'(w) || log_data[base + w] !== exp_w) bad_data++;
      end
    end else begin
      bad_data = -1;
    end
    n_tests++; if (bad_data !== 0)       begin n_fail++; $display("FAIL full_addr_data bad_words=%0d exp=0", bad_data); end
    step();
  endtask

  task automatic test_illegal_len();
    int base;
    base = log_addr.size();
    do_start(8'd0);
    n_tests++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL illegal0 done_err=%b%b exp=11", done, err); end
    step();
    n_tests++; if (done !== 1'b0 || err !== 1'b1 || core_hold !== 1'b0) begin n_fail++; $display("FAIL illegal0_after done_err_hold=%b%b%b exp=010", done, err, core_hold); end
    do_start(8'd129);
    n_tests++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL illegal129 done_err=%b%b exp=11", done, err); end
    step();
    n_tests++; if (log_addr.size() - base !== 0) begin n_fail++; $display("FAIL illegal_no_write got=%0d exp=0", log_addr.size() - base); end
    do_start(8'd1);
    n_tests++; if (err !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_recover err_ready=%b%b exp=01", err, s_ready); end
    send_word(32'h11223344);
    n_tests++; if (wdata !== 32'h11223344 || we !== 1'b1) begin n_fail++; $display("FAIL illegal_recover_write wdata=%h we=%b exp 11223344 1", wdata, we); end
    step();
    step();
  endtask

  task automatic test_abort();
    int base;
    base = log_addr.size();
    do_start(8'd5);
    send_word(32'ha0000001); send_word(32'ha0000002); send_word(32'ha0000003);
    send_byte(8'h55); send_byte(8'h66);
    abort = 1'b1; s_valid = 1'b1; s_data = 8'h77;
    step();
    abort = 1'b0; s_valid = 1'b0;
    n_tests++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL abort_load done_err=%b%b exp=11", done, err); end
    n_tests++; if (count !== 8'd3)       begin n_fail++; $display("FAIL abort_load_count got=%h exp=3", count); end
    step();
    n_tests++; if (core_hold !== 1'b0 || log_addr.size() - base !== 3) begin n_fail++; $display("FAIL abort_load_writes hold=%b writes=%0d exp 0 3", core_hold, log_addr.size() - base); end

    base = log_addr.size();
    do_start(8'd5);
    n_tests++; if (err !== 1'b0)         begin n_fail++; $display("FAIL abort_restart_err got=%b exp=0", err); end
    send_word(32'hb0000001); send_word(32'hb0000002); send_word(32'hb0000003); send_word(32'hb0000004);
    abort = 1'b1;
    n_tests++; if (we !== 1'b1 || waddr !== 7'd3) begin n_fail++; $display("FAIL abort_write_cycle we=%b waddr=%h exp 1 3", we, waddr); end
    step();
    abort = 1'b0;
    n_tests++; if (done !== 1'b1 || err !== 1'b1 || count !== 8'd4) begin n_fail++; $display("FAIL abort_write done=%b err=%b count=%h exp 1 1 4", done, err, count); end
    n_tests++; if (log_addr.size() - base !== 4 || log_data[log_data.size()-1] !== 32'hb0000004) begin n_fail++; $display("FAIL abort_write_log writes=%0d exp=4", log_addr.size() - base); end
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_tests++; if (core_hold !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_idle hold_done=%b%b exp=00", core_hold, done); end
  endtask

  task automatic test_mid_reset();
    int base;
    do_start(8'd3);
    send_word(32'hc0000001);
    send_byte(8'h12); send_byte(8'h34);
    #1;
    reset = 1'b0;
    #1;
    n_tests++; if ({s_ready, we, core_hold, done, err} !== 5'b0) begin n_fail++; $display("FAIL midreset_flags got=%b exp=00000", {s_ready, we, core_hold, done, err}); end
    n_tests++; if (waddr !== 7'd0 || wdata !== 32'd0 || count !== 8'd0) begin n_fail++; $display("FAIL midreset_data waddr=%h wdata=%h count=%h exp 0", waddr, wdata, count); end
    reset = 1'b1;
    step();
    base = log_addr.size();
    do_start(8'd2);
    send_word(32'hd00000aa);
    send_word(32'hd00000bb);
    step();
    n_tests++; if (done !== 1'b1 || count !== 8'd2) begin n_fail++; $display("FAIL midreset_reload done=%b count=%h exp 1 2", done, count); end
    n_tests++; if (log_addr.size() - base !== 2 || log_addr[base] !== 7'd0 || log_data[base] !== 32'hd00000aa
                   || log_addr[base+1] !== 7'd1 || log_data[base+1] !== 32'hd00000bb) begin
      n_fail++; $display("FAIL midreset_writes count=%0d exp=2 at 0,1", log_addr.size() - base);
    end
    step();
  endtask

  task automatic test_start_busy();
    do_start(8'd2);
    send_byte(8'h01);
    start = 1'b1; len = 8'd1;
    send_byte(8'h02);
    start = 1'b0;
    send_byte(8'h03); send_byte(8'h04);
    n_tests++; if (we !== 1'b1 || wdata !== 32'h04030201) begin n_fail++; $display("FAIL busy_write we=%b wdata=%h exp 1 04030201", we, wdata); end
    step();
    n_tests++; if (done !== 1'b0 || s_ready !== 1'b1 || count !== 8'd1) begin n_fail++; $display("FAIL busy_continue done=%b ready=%b count=%h exp 0 1 1", done, s_ready, count); end
    send_word(32'h08070605);
    step();
    n_tests++; if (done !== 1'b1 || count !== 8'd2 || err !== 1'b0) begin n_fail++; $display("FAIL busy_done done=%b count=%h err=%b exp 1 2 0", done, count, err); end
    step();
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    len     = 8'd0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'd0;
    #1;
    test_reset();
    test_single_word();
    test_full_backpressure();
    test_illegal_len();
    test_abort();
    test_mid_reset();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_imem_loader
`default_nettype wire
